instr_mem_responder: RTL and testbench



---
 rtl/instr_mem_responder.sv | 125 ++++++++++++
 tb/tb_instr_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: grants req/gnt fetches against a word RAM
// and returns words in order, LATENCY cycles after each grant.
module instr_mem_responder #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  stall_i,
  input  logic                  load_we_i,
  input  logic [WORD_WIDTH-1:0] load_addr_i,
  input  logic [WORD_WIDTH-1:0] load_wdata_i,
  output logic                  err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      load_idx;
  logic                  fetch_in_range;
  logic                  fetch_misaligned;
  logic                  load_in_range;
  logic                  unused_load_lsb;

  logic                  gnt;
  logic                  retire;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
  logic [WORD_WIDTH-1:0] ram_q;
  logic                  oor_q;
  logic [WORD_WIDTH-1:0] rd_word;
  logic [WORD_WIDTH-1:0] head_word;

  assign fetch_idx        = instr_addr_i[IDX_W+1:2];
  assign fetch_in_range   = (instr_addr_i >> (IDX_W + 2)) == '0;
  assign fetch_misaligned = |instr_addr_i[1:0];
  assign load_idx         = load_addr_i[IDX_W+1:2];
  assign load_in_range    = (load_addr_i >> (IDX_W + 2)) == '0;
  assign unused_load_lsb  = ^load_addr_i[1:0];

  // A response leaving the pipeline frees its slot in the same cycle.
  assign retire = valid_q[LATENCY-1];
  assign gnt    = instr_req_i & ~stall_i & ~load_we_i & ~rst &
                  ((cnt_q < CNT_MAX) | retire);

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !retire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!gnt && retire) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    valid_d = (valid_q << 1) | LATENCY'(gnt);
    rdata_d = retire ? head_word : rdata_q;
    err_d   = err_q | (gnt & (fetch_misaligned | ~fetch_in_range));
  end

  // Data-path registers carry no reset; they are only observed behind valid_q.
  always_ff @(posedge clk) begin
    if (load_we_i && load_in_range) begin
      mem[load_idx] <= load_wdata_i;
    end
    if (gnt && fetch_in_range) begin
      ram_q <= mem[fetch_idx];
    end
    if (gnt) begin
      oor_q <= ~fetch_in_range;
    end
  end

  assign rd_word = oor_q ? NOP_INSTR : ram_q;

  // Stage i of the data pipe lines up with valid_q[i+1].
  if (LATENCY == 1) begin : g_lat1
    assign head_word = rd_word;
  end else begin : g_latn
    logic [WORD_WIDTH-1:0] dpipe_q [LATENCY-1];

    always_ff @(posedge clk) begin
      dpipe_q[0] <= rd_word;
      for (int i = 1; i < int'(LATENCY) - 1; i++) begin
        dpipe_q[i] <= dpipe_q[i-1];
      end
    end

    assign head_word = dpipe_q[LATENCY-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = retire;
  assign instr_rdata_o  = rdata_d;
  assign err_o          = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: four instances with different latency/capacity
// share stimulus; each scenario checks one of them against a scoreboard.
module tb_instr_mem_responder;

  localparam int N_DUT = 4;
  localparam int LAT_P [N_DUT] = '{1, 2, 2, 3};
  localparam int MAX_P [N_DUT] = '{2, 2, 1, 3};

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_wdata = '0;

  logic [N_DUT-1:0] gnt;
  logic [N_DUT-1:0] rvalid;
  logic [N_DUT-1:0] err;
  logic [31:0]      rdata [N_DUT];

  logic [31:0] mem_m [1024];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    instr_mem_responder #(
      .LATENCY(LAT_P[gi]),
      .MAX_OUTSTANDING(MAX_P[gi])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .instr_req_i(instr_req),
      .instr_addr_i(instr_addr),
      .instr_gnt_o(gnt[gi]),
      .instr_rvalid_o(rvalid[gi]),
      .instr_rdata_o(rdata[gi]),
      .stall_i(stall),
      .load_we_i(load_we),
      .load_addr_i(load_addr),
      .load_wdata_i(load_wdata),
      .err_o(err[gi])
    );
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a[31:12] != 20'd0) return 32'h00000013;
    return mem_m[a[11:2]];
  endfunction

  task automatic idle(input int n);
    instr_req = 1'b0;
    stall     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    load_we    = 1'b1;
    load_addr  = a;
    load_wdata = w;
    if (a[31:12] == 20'd0) mem_m[a[11:2]] = w;
    $display("load addr=%h data=%h", a, w);
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h14;
    @(negedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d: gnt=%b rvalid=%b err=%b rdata=%h, expected all zero",
                 i, gnt[i], rvalid[i], err[i], rdata[i]);
      end
    end
    @(negedge clk);
    rst       = 1'b0;
    instr_req = 1'b0;
  endtask

  task automatic test_load();
    do_load(32'h0000_0000, 32'h0000_00A0);
    do_load(32'h0000_0004, 32'h0000_00A1);
    do_load(32'h0000_0008, 32'h0000_00A2);
    do_load(32'h0000_0014, 32'hDEADBEEF);
    do_load(32'h0000_0FFC, 32'h1234_5678);
    do_load(32'h0010_0014, 32'hBAD0_BAD0);
  endtask

  // Streams n fetches at dut d; gnt is checked every cycle, each rvalid is
  // popped from the scoreboard and checked for data and arrival cycle.
  task automatic test_stream(input string name, input int d, input int n,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [7:0] stall_mask);
    logic [31:0] addrs [3];
    int   sent, got, out_m, cyc;
    logic exp_gnt;
    exp_t e;
    addrs[0] = a0;
    addrs[1] = a1;
    addrs[2] = a2;
    sent = 0; got = 0; out_m = 0; cyc = 0;
    sb_q.delete();
    while (got < n && cyc < 40) begin
      @(negedge clk);
      instr_req  = (sent < n);
      instr_addr = (sent < n) ? addrs[sent] : 32'h0;
      stall      = (cyc < 8) ? stall_mask[cyc] : 1'b0;
      #1;
      exp_gnt = instr_req & ~stall & ((out_m < MAX_P[d]) | (rvalid[d] === 1'b1));
      checks++;
      if (gnt[d] !== exp_gnt) begin
        errors++;
        $display("FAIL %s gnt cycle %0d: got %b expected %b", name, cyc, gnt[d], exp_gnt);
      end
      if (rvalid[d] === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s spurious rvalid cycle %0d: data %h, no response expected", name, cyc, rdata[d]);
        end else begin
          e = sb_q.pop_front();
          got++;
          out_m--;
          $display("txn %s dut%0d cycle %0d rdata=%h", name, d, cyc, rdata[d]);
          if (rdata[d] !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL %s response: got %h at cycle %0d, expected %h at cycle %0d",
                     name, rdata[d], cyc, e.data, e.due);
          end
        end
      end
      if (gnt[d] === 1'b1 && sent < n) begin
        e.data = exp_word(addrs[sent]);
        e.due  = cyc + LAT_P[d];
        sb_q.push_back(e);
        sent++;
        out_m++;
      end
      cyc++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s timeout: got %0d responses, expected %0d", name, got, n);
    end
    instr_req = 1'b0;
    stall     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rvalid[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s trailing rvalid: got %b expected 0", name, rvalid[d]);
      end
    end
  endtask

  task automatic test_single();
    test_stream("single", 0, 1, 32'h14, 32'h0, 32'h0, 8'h00);
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL single err: got %b expected 0", err[0]);
    end
  endtask

  task automatic test_back_to_back();
    test_stream("back_to_back", 1, 3, 32'h0, 32'h4, 32'h8, 8'h00);
  endtask

  task automatic test_max_outstanding();
    test_stream("max_outstanding", 2, 3, 32'h0, 32'h4, 32'hFFC, 8'h00);
  endtask

  task automatic test_stall();
    test_stream("stall", 1, 2, 32'h14, 32'h8, 32'h0, 8'b0000_0111);
  endtask

  task automatic test_load_priority();
    logic [31:0] old0;
    old0 = mem_m[0];
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h0;
    #1;
    checks++;
    if (gnt[1] !== 1'b1) begin
      errors++;
      $display("FAIL load_prio gnt0: got %b expected 1", gnt[1]);
    end
    @(negedge clk);
    instr_addr = 32'h4;
    load_we    = 1'b1;
    load_addr  = 32'h0;
    load_wdata = 32'h0000_0055;
    mem_m[0]   = 32'h0000_0055;
    #1;
    checks++;
    if (gnt[1] !== 1'b0) begin
      errors++;
      $display("FAIL load_prio gnt during load: got %b expected 0", gnt[1]);
    end
    @(negedge clk);
    load_we = 1'b0;
    #1;
    checks++;
    if (gnt[1] !== 1'b1 || rvalid[1] !== 1'b1 || rdata[1] !== old0) begin
      errors++;
      $display("FAIL load_prio old word: gnt=%b rvalid=%b rdata=%h, expected 1 1 %h",
               gnt[1], rvalid[1], rdata[1], old0);
    end
    @(negedge clk);
    instr_req = 1'b0;
    #1;
    checks++;
    if (rvalid[1] !== 1'b0 || rdata[1] !== old0) begin
      errors++;
      $display("FAIL load_prio hold: rvalid=%b rdata=%h, expected 0 %h", rvalid[1], rdata[1], old0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== mem_m[1]) begin
      errors++;
      $display("FAIL load_prio second: rvalid=%b rdata=%h, expected 1 %h", rvalid[1], rdata[1], mem_m[1]);
    end
    $display("txn load_prio dut1 rdata=%h", rdata[1]);
    idle(5);
  endtask

  task automatic test_errors();
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL errors pre: err got %b expected 0", err[0]);
    end
    test_stream("misaligned", 0, 1, 32'h16, 32'h0, 32'h0, 8'h00);
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL misaligned err: got %b expected 1", err[0]);
    end
    pulse_reset();
    #1;
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL err after reset: got %b expected 0", err[0]);
    end
    test_stream("out_of_range", 0, 1, 32'h0010_0000, 32'h0, 32'h0, 8'h00);
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL out_of_range err: got %b expected 1", err[0]);
    end
    idle(6);
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL err sticky: got %b expected 1", err[0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_req  = 1'b1;
    instr_addr = 32'h0;
    #1;
    checks++;
    if (gnt[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid gnt0: got %b expected 1", gnt[3]);
    end
    @(negedge clk);
    instr_addr = 32'h4;
    #1;
    checks++;
    if (gnt[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid gnt1: got %b expected 1", gnt[3]);
    end
    @(negedge clk);
    instr_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (rvalid[3] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid discarded rvalid cycle %0d: got %b expected 0", i, rvalid[3]);
      end
      @(negedge clk);
    end
    checks++;
    if (err[3] !== 1'b0 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid err cleared: got %b/%b expected 0/0", err[3], err[0]);
    end
    test_stream("post_reset", 3, 1, 32'h0, 32'h0, 32'h0, 8'h00);
    checks++;
    if (err[3] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset err: got %b expected 0", err[3]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_back_to_back();
    test_max_outstanding();
    test_stall();
    test_load_priority();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
